add_sub_serial_ovf: RTL and testbench
=====================================

# add_sub_serial_ovf

Parametrised, multi-cycle two's-complement adder/subtractor with carry and signed-overflow detection, plus a sticky overflow flag. It processes operands LSB-first, DIGIT bits per clock, under a start/ready/done handshake. It replaces the fixed 4-bit combinational add/sub datapath on the board-level designs. Results and flags are registered and held for LED display until the next operation completes.

## Interface
- WIDTH, 8, operand and result width in bits; WIDTH ≥ 2.
- DIGIT, 1, bits processed per cycle; must divide WIDTH evenly. N = WIDTH/DIGIT.

Ports:
- CLOCK_50  in  1  system clock; all logic is on the rising edge.
- RST  in  1  reset, synchronous and active-high.
- START  in  1  request a new operation; sampled only while READY=1.
- SUB  in  1  operation select: 0 = A+B, 1 = A−B (B is inverted and carry-in is 1).
- A  in  WIDTH  operand A, two's complement.
- B  in  WIDTH  operand B, two's complement.
- CLR_STICKY  in  1  clears OVF_STICKY.
- READY  out  1  block is idle and will accept START.
- DONE  out  1  one-cycle pulse: RESULT and flags were updated on this cycle's entry.
- RESULT  out  WIDTH  last completed sum/difference, modulo 2^WIDTH.
- COUT  out  1  carry out of the MSB. For SUB this is 1 when no borrow occurred.
- OVF  out  1  signed overflow of the last completed operation.
- OVF_STICKY  out  1  set by any completed operation with OVF=1; held until cleared.

## Operation
- FSM states:
  - IDLE: READY=1.
  - RUN: N cycles, one digit per cycle.
  - DONE: exactly 1 cycle, DONE=1.
  - Transitions: IDLE→RUN on START; RUN→DONE after digit N−1; DONE→IDLE unconditionally.
- On accept, A, B (already XORed with SUB) and the carry register (loaded with SUB) are captured. The digit counter is set to 0. Later changes on A, B, SUB and START have no effect until the next IDLE.
- START outside IDLE is ignored. It is neither queued nor an error.
- Each RUN cycle:
  - Adds DIGIT bits of A and B plus the carry register.
  - Shifts the DIGIT-bit partial sum into an internal WIDTH-bit result shift register.
  - Updates the carry register.
  - Records the carry into the MSB when the final digit is processed.
- On the RUN→DONE edge:
  - RESULT is loaded from the shift register.
  - COUT = final carry.
  - OVF = carry-into-MSB XOR carry-out-of-MSB.
- RESULT, COUT and OVF hold their previous values throughout RUN and change only on the RUN→DONE edge.
- OVF_STICKY update on the RUN→DONE edge:
  - Set if the new OVF=1.
  - Otherwise cleared if CLR_STICKY=1.
  - Set wins when both occur on the same edge.
  - CLR_STICKY is honoured in every state.
- Reset:
  - State IDLE; READY=1; DONE=0.
  - RESULT, COUT, OVF and OVF_STICKY all 0; internal registers 0.
  - Reset asserted mid-RUN aborts the operation with no DONE pulse, and RESULT is not updated.

## Timing
- The accept edge is the rising edge at the end of cycle 0, with START=1 and READY=1.
- Cycles 1..N are RUN; READY=0.
- Cycle N+1 is DONE: DONE=1, READY=0, and the new RESULT and flags are visible.
- Cycle N+2: READY=1. A START here is accepted at the end of N+2.
- Latency from the accept edge to DONE=1 is N+1 cycles. Throughput is one operation per N+2 cycles.
- With WIDTH=4, DIGIT=1: DONE is asserted 5 cycles after the accept edge.
- With WIDTH=8, DIGIT=2: DONE is asserted 5 cycles after the accept edge.
- No combinational path from any input to any output. READY and DONE are decoded from registered state only.

## Test plan
- WIDTH=4, DIGIT=1, A=5, B=2, SUB=0 -> DONE in cycle 5; RESULT=7, COUT=0, OVF=0, OVF_STICKY=0.
- WIDTH=4, A=7, B=1, SUB=0 -> RESULT=8 (−8), COUT=0, OVF=1, OVF_STICKY=1. A following 3−5 (SUB=1) -> RESULT=14, COUT=0, OVF=0, OVF_STICKY stays 1.
- WIDTH=4, A=8, B=1, SUB=1 (−8−1) -> RESULT=7, COUT=1, OVF=1.
- WIDTH=4, CLR_STICKY=1 held on the same edge as the DONE entry of an overflowing op -> OVF_STICKY=1. CLR_STICKY pulsed later in IDLE -> 0.
- WIDTH=4, assert RST in RUN cycle 2, then release and idle 10 cycles -> no DONE pulse; all outputs 0; READY=1 the cycle after reset deasserts. START pulses during RUN and DONE are ignored (exactly one DONE per accepted START).
- WIDTH=8, DIGIT=2: 100+27 -> RESULT=127, OVF=0, DONE 5 cycles after accept. 100+28 -> RESULT=0x80, OVF=1, COUT=0. Back-to-back STARTs complete one operation per 6 cycles.

Source files
------------

// File: rtl/add_sub_serial_ovf.sv
// Digit-serial two's-complement adder/subtractor, LSB-first, DIGIT bits per clock.
// Result, carry and signed-overflow flags are registered and held until the next completion.
module add_sub_serial_ovf #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             CLOCK_50,
  input  logic             RST,
  input  logic             START,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CLR_STICKY,
  output logic             READY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             COUT,
  output logic             OVF,
  output logic             OVF_STICKY
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned DW = DIGIT + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sr_q, result_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, ovf_q, sticky_q;

  logic [DW-1:0]    sum;
  logic [WIDTH-1:0] sr_next;
  logic             cin_msb, last, ovf_new;

  always_comb begin
    sum = DW'(a_q[DIGIT-1:0]) + DW'(b_q[DIGIT-1:0]) + DW'(carry_q);
    // Sum bit = a ^ b ^ cin, so the carry into the top bit of the digit falls out directly.
    cin_msb = sum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
    last    = (cnt_q == CW'(N - 1));
    ovf_new = cin_msb ^ sum[DIGIT];
    sr_next = (sr_q >> DIGIT) | (WIDTH'(sum[DIGIT-1:0]) << (WIDTH - DIGIT));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (START) state_d = StRun;
      StRun:   if (last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      sr_q     <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && START) begin
        a_q     <= A;
        b_q     <= B ^ {WIDTH{SUB}};
        carry_q <= SUB;
        cnt_q   <= '0;
        sr_q    <= '0;
      end else if (state_q == StRun) begin
        a_q     <= a_q >> DIGIT;
        b_q     <= b_q >> DIGIT;
        carry_q <= sum[DIGIT];
        cnt_q   <= cnt_q + CW'(1);
        sr_q    <= sr_next;
        if (last) begin
          result_q <= sr_next;
          cout_q   <= sum[DIGIT];
          ovf_q    <= ovf_new;
        end
      end
      // A completing overflow wins over a simultaneous clear.
      if (state_q == StRun && last && ovf_new) sticky_q <= 1'b1;
      else if (CLR_STICKY)                     sticky_q <= 1'b0;
    end
  end

  assign READY      = (state_q == StIdle);
  assign DONE       = (state_q == StDone);
  assign RESULT     = result_q;
  assign COUT       = cout_q;
  assign OVF        = ovf_q;
  assign OVF_STICKY = sticky_q;

endmodule

// File: tb/tb_add_sub_serial_ovf.sv
// Randomised and directed bench for add_sub_serial_ovf: a 4-bit/1-digit and an
// 8-bit/2-digit instance are checked against an arithmetic reference model.
module tb_add_sub_serial_ovf;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start4, sub4, clr4, ready4, done4, cout4, ovf4, st4;
  logic [3:0] a4, b4, res4;
  logic       start8, sub8, clr8, ready8, done8, cout8, ovf8, st8;
  logic [7:0] a8, b8, res8;

  int checks   = 0;
  int failures = 0;
  bit ms4      = 0;
  bit ms8      = 0;

  add_sub_serial_ovf #(.WIDTH(4), .DIGIT(1)) u_dut4 (
    .CLOCK_50(clk), .RST(rst), .START(start4), .SUB(sub4), .A(a4), .B(b4),
    .CLR_STICKY(clr4), .READY(ready4), .DONE(done4), .RESULT(res4), .COUT(cout4),
    .OVF(ovf4), .OVF_STICKY(st4)
  );

  add_sub_serial_ovf #(.WIDTH(8), .DIGIT(2)) u_dut8 (
    .CLOCK_50(clk), .RST(rst), .START(start8), .SUB(sub8), .A(a8), .B(b8),
    .CLR_STICKY(clr8), .READY(ready8), .DONE(done8), .RESULT(res8), .COUT(cout8),
    .OVF(ovf8), .OVF_STICKY(st8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input int w, input int a, input int b, input bit sub,
                                output int res, output bit co, output bit ov);
    int mask, bb, full, sa, sb, sr;
    mask = (1 << w) - 1;
    bb   = sub ? (~b & mask) : b;
    full = a + bb + int'(sub);
    res  = full & mask;
    co   = ((full >> w) & 1) != 0;
    sa   = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb   = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    sr   = sub ? sa - sb : sa + sb;
    ov   = (sr < -(1 << (w - 1))) || (sr > (1 << (w - 1)) - 1);
  endfunction

  task automatic drive(input int which, input bit s, input bit sb, input int a, input int b,
                       input bit c);
    if (which == 4) begin
      start4 = s; sub4 = sb; a4 = 4'(a); b4 = 4'(b); clr4 = c;
    end else begin
      start8 = s; sub8 = sb; a8 = 8'(a); b8 = 8'(b); clr8 = c;
    end
  endtask

  function automatic logic get_ready(input int which);
    return (which == 4) ? ready4 : ready8;
  endfunction
  function automatic logic get_done(input int which);
    return (which == 4) ? done4 : done8;
  endfunction
  function automatic logic [7:0] get_res(input int which);
    return (which == 4) ? {4'b0, res4} : res8;
  endfunction

  // One full operation; START is toggled randomly while busy and must be ignored.
  task automatic run_op(input int which, input int a, input int b, input bit sub, input bit clr);
    int res, k;
    bit co, ov, ms;
    logic [7:0] prev_res;
    model(which, a, b, sub, res, co, ov);
    k = 0;
    while (!get_ready(which) && k < 20) begin
      tick();
      k++;
    end
    check("ready_before_start", 32'(get_ready(which)), 1);
    prev_res = get_res(which);
    drive(which, 1, sub, a, b, clr);
    tick();
    k = 0;
    while (!get_done(which) && k < 20) begin
      if (k == 1) begin
        check("result_hold_in_run", 32'(get_res(which)), 32'(prev_res));
        check("ready_low_in_run", 32'(get_ready(which)), 0);
      end
      drive(which, 1'($urandom_range(0, 1)), ~sub, int'($urandom), int'($urandom), clr);
      tick();
      k++;
    end
    check("latency", 32'(k + 1), 5);
    ms = (which == 4) ? ms4 : ms8;
    if (ov) ms = 1;
    else if (clr) ms = 0;
    if (which == 4) ms4 = ms; else ms8 = ms;
    if (which == 4) begin
      check("result4", 32'(res4), 32'(res));
      check("cout4", 32'(cout4), 32'(co));
      check("ovf4", 32'(ovf4), 32'(ov));
      check("sticky4", 32'(st4), 32'(ms));
    end else begin
      check("result8", 32'(res8), 32'(res));
      check("cout8", 32'(cout8), 32'(co));
      check("ovf8", 32'(ovf8), 32'(ov));
      check("sticky8", 32'(st8), 32'(ms));
    end
    drive(which, 1, sub, a, b, 0);
    tick();
    check("done_single_pulse", 32'(get_done(which)), 0);
    check("ready_after_done", 32'(get_ready(which)), 1);
    drive(which, 0, 0, 0, 0, 0);
  endtask

  task automatic pulse_clear(input int which);
    drive(which, 0, 0, 0, 0, 1);
    tick();
    drive(which, 0, 0, 0, 0, 0);
    if (which == 4) begin
      ms4 = 0;
      check("sticky4_cleared", 32'(st4), 32'(ms4));
    end else begin
      ms8 = 0;
      check("sticky8_cleared", 32'(st8), 32'(ms8));
    end
  endtask

  initial begin
    int t, nd, t0, t1, w;
    bit seen;
    rst = 1;
    drive(4, 0, 0, 0, 0, 0);
    drive(8, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 0;
    check("rst_ready4", 32'(ready4), 1);
    check("rst_done4", 32'(done4), 0);
    check("rst_out4", {25'b0, res4, cout4, ovf4, st4}, 0);
    check("rst_ready8", 32'(ready8), 1);
    check("rst_out8", {21'b0, res8, cout8, ovf8, st8}, 0);

    run_op(4, 5, 2, 0, 0);
    run_op(4, 7, 1, 0, 0);
    run_op(4, 3, 5, 1, 0);
    run_op(4, 8, 1, 1, 0);
    pulse_clear(4);
    run_op(4, 7, 1, 0, 1);
    pulse_clear(4);

    // Reset in the second RUN cycle aborts with no DONE and zeroed outputs.
    drive(4, 1, 0, 7, 1, 0);
    tick();
    drive(4, 0, 0, 0, 0, 0);
    tick();
    rst = 1;
    tick();
    rst = 0;
    ms4 = 0;
    ms8 = 0;
    check("abort_ready", 32'(ready4), 1);
    check("abort_outputs", {25'b0, res4, cout4, ovf4, st4}, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (done4) seen = 1;
      tick();
    end
    check("abort_no_done", 32'(seen), 0);
    check("abort_result_kept", 32'(res4), 0);

    run_op(8, 100, 27, 0, 0);
    run_op(8, 100, 28, 0, 0);
    pulse_clear(8);

    // Held START: completions must be spaced one per 6 cycles.
    drive(8, 1, 0, 10, 20, 0);
    t = 0; nd = 0; t0 = -1; t1 = -1;
    while (nd < 2 && t < 40) begin
      if (done8) begin
        if (nd == 0) t0 = t; else t1 = t;
        nd++;
      end
      tick();
      t++;
    end
    drive(8, 0, 0, 0, 0, 0);
    check("b2b_period", 32'(t1 - t0), 6);
    check("b2b_result", 32'(res8), 30);

    for (int i = 0; i < 40; i++) begin
      w = (i % 2 == 1) ? 8 : 4;
      run_op(w, int'($urandom) & ((1 << w) - 1), int'($urandom) & ((1 << w) - 1),
             1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
